// File: rtl/zap_mode16_unpack_queue_if.sv
// Fetch-side handshake and decoder-side record bus for zap_mode16_unpack_queue.
// The master modport belongs to the fetch/decode environment and the slave modport to the queue.
interface zap_mode16_unpack_queue_if #(
    parameter int unsigned DEPTH = 8
);
    localparam int unsigned LW = $clog2(DEPTH) + 1;

    // Fetch side
    logic            i_cpsr_ff_t;
    logic [31:0]     i_word;
    logic [31:0]     i_word_pc;
    logic            i_word_valid;
    logic            i_word_iabort;
    logic            o_word_ready;

    // Record side
    logic [31:0]     o_instruction;
    logic            o_valid;
    logic            o_pair;
    logic            o_thumb;
    logic            o_iabort;
    logic [31:0]     o_pc;
    logic [31:0]     o_pc_plus_8;
    logic [LW-1:0]   o_level;

    modport master (
        output i_cpsr_ff_t, i_word, i_word_pc, i_word_valid, i_word_iabort,
        input  o_word_ready, o_instruction, o_valid, o_pair, o_thumb,
               o_iabort, o_pc, o_pc_plus_8, o_level
    );

    modport slave (
        input  i_cpsr_ff_t, i_word, i_word_pc, i_word_valid, i_word_iabort,
        output o_word_ready, o_instruction, o_valid, o_pair, o_thumb,
               o_iabort, o_pc, o_pc_plus_8, o_level
    );
endinterface

// File: rtl/zap_mode16_unpack_queue.sv
// Halfword unpack queue between fetch and the mode16 decoder.
// Fetch words are split into halfword entries in a circular queue, and one registered
// instruction record is emitted per load cycle.
// Optional feature macro: ZAP_MODE16_PAIR_FUSE_EN (fuses BL prefix/suffix pairs).
module zap_mode16_unpack_queue #(
    parameter int unsigned DEPTH = 8
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_clear_from_writeback,
    input  logic i_data_stall,
    input  logic i_clear_from_alu,
    input  logic i_clear_from_decode,
    input  logic i_stall_from_shifter,
    input  logic i_stall_from_issue,
    input  logic i_stall_from_decode,
    zap_mode16_unpack_queue_if.slave bus
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned LW = PW + 1;

    // Queue storage
    logic [15:0]      hw_q    [DEPTH];
    logic [31:0]      pc_q    [DEPTH];
    logic [DEPTH-1:0] thumb_q;
    logic [DEPTH-1:0] abort_q;

    logic [PW-1:0] rd_q, rd_d, wr_q, wr_d;
    logic [LW-1:0] level_q, level_d;

    // Output record registers
    logic        rec_valid_q, rec_valid_d;
    logic [31:0] rec_instr_q, rec_instr_d;
    logic        rec_pair_q, rec_pair_d;
    logic        rec_thumb_q, rec_thumb_d;
    logic        rec_iabort_q, rec_iabort_d;
    logic [31:0] rec_pc_q, rec_pc_d;
    logic [31:0] rec_pc8_q, rec_pc8_d;

    logic        stall, flush, load, word_ready, has2, emit, fuse;
    logic [1:0]  push_n, pop_n;
    logic [PW-1:0] head, nxt;
    logic [15:0] e0_hw, e1_hw;
    logic [31:0] e0_pc, e1_pc, instr_n;
    logic        e0_abort;

    // Priority chain, enqueue split and head decode
    always_comb begin
        stall      = i_stall_from_shifter | i_stall_from_issue | i_stall_from_decode | i_data_stall;
        flush      = i_clear_from_writeback | (i_clear_from_alu & ~i_data_stall)
                   | (i_clear_from_decode & ~stall);
        load       = ~flush & ~stall;
        word_ready = level_q <= LW'(DEPTH - 2);

        // Enqueue: split the fetch word into one or two entries
        push_n   = 2'd0;
        e0_hw    = bus.i_word[15:0];
        e1_hw    = bus.i_word[31:16];
        e0_pc    = bus.i_word_pc;
        e1_pc    = bus.i_word_pc;
        e0_abort = 1'b0;
        if (bus.i_word_iabort) begin
            push_n   = 2'd1;
            e0_hw    = 16'd0;
            e0_abort = 1'b1;
        end else if (bus.i_cpsr_ff_t && !bus.i_word_pc[1]) begin
            push_n = 2'd2;
            e1_pc  = bus.i_word_pc + 32'd2;
        end else if (bus.i_cpsr_ff_t) begin
            push_n = 2'd1;
            e0_hw  = bus.i_word[31:16];
        end else begin
            push_n = 2'd2;
        end
        if (!(bus.i_word_valid && word_ready && !flush)) begin
            push_n = 2'd0;
        end

        // Dequeue: build the next record from the head
        head         = rd_q;
        nxt          = rd_q + PW'(1);
        has2         = level_q >= LW'(2);
        pop_n        = 2'd0;
        emit         = 1'b0;
        fuse         = 1'b0;
        instr_n      = {16'd0, hw_q[head]};
        rec_valid_d  = rec_valid_q;
        rec_instr_d  = rec_instr_q;
        rec_pair_d   = rec_pair_q;
        rec_thumb_d  = rec_thumb_q;
        rec_iabort_d = rec_iabort_q;
        rec_pc_d     = rec_pc_q;
        rec_pc8_d    = rec_pc8_q;

        if (flush) begin
            rec_valid_d  = 1'b0;
            rec_iabort_d = 1'b0;
            rec_pair_d   = 1'b0;
        end else if (load) begin
            if (level_q == '0) begin
                rec_valid_d = 1'b0;
            end else if (abort_q[head]) begin
                emit    = 1'b1;
                instr_n = 32'd0;
                pop_n   = 2'd1;
            end else if (!thumb_q[head]) begin
                if (has2) begin
                    emit    = 1'b1;
                    instr_n = {hw_q[nxt], hw_q[head]};
                    pop_n   = 2'd2;
                end else begin
                    rec_valid_d = 1'b0;
                end
`ifdef ZAP_MODE16_PAIR_FUSE_EN
            end else if (hw_q[head][15:11] == 5'b11110) begin
                if (!has2) begin
                    rec_valid_d = 1'b0;
                end else if (thumb_q[nxt] && !abort_q[nxt] && hw_q[nxt][15:11] == 5'b11111) begin
                    emit    = 1'b1;
                    fuse    = 1'b1;
                    instr_n = {hw_q[head], hw_q[nxt]};
                    pop_n   = 2'd2;
                end else begin
                    emit  = 1'b1;
                    pop_n = 2'd1;
                end
`endif
            end else begin
                emit  = 1'b1;
                pop_n = 2'd1;
            end
        end

        if (emit) begin
            rec_valid_d  = 1'b1;
            rec_instr_d  = instr_n;
            rec_pair_d   = fuse;
            rec_iabort_d = abort_q[head];
            rec_thumb_d  = thumb_q[head];
            rec_pc_d     = pc_q[head];
            rec_pc8_d    = pc_q[head] + (thumb_q[head] ? 32'd4 : 32'd8);
        end

        if (flush) begin
            level_d = '0;
            rd_d    = '0;
            wr_d    = '0;
        end else begin
            level_d = level_q + LW'(push_n) - LW'(pop_n);
            rd_d    = rd_q + PW'(pop_n);
            wr_d    = wr_q + PW'(push_n);
        end
    end

    // Control and output record registers
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            rd_q         <= '0;
            wr_q         <= '0;
            level_q      <= '0;
            rec_valid_q  <= 1'b0;
            rec_instr_q  <= 32'd0;
            rec_pair_q   <= 1'b0;
            rec_thumb_q  <= 1'b0;
            rec_iabort_q <= 1'b0;
            rec_pc_q     <= 32'd0;
            rec_pc8_q    <= 32'd0;
        end else begin
            rd_q         <= rd_d;
            wr_q         <= wr_d;
            level_q      <= level_d;
            rec_valid_q  <= rec_valid_d;
            rec_instr_q  <= rec_instr_d;
            rec_pair_q   <= rec_pair_d;
            rec_thumb_q  <= rec_thumb_d;
            rec_iabort_q <= rec_iabort_d;
            rec_pc_q     <= rec_pc_d;
            rec_pc8_q    <= rec_pc8_d;
        end
    end

    // Entry storage writes at the tail
    always_ff @(posedge i_clk) begin
        if (!i_reset && push_n != 2'd0) begin
            hw_q[wr_q]    <= e0_hw;
            pc_q[wr_q]    <= e0_pc;
            thumb_q[wr_q] <= bus.i_cpsr_ff_t;
            abort_q[wr_q] <= e0_abort;
            if (push_n == 2'd2) begin
                hw_q[wr_q + PW'(1)]    <= e1_hw;
                pc_q[wr_q + PW'(1)]    <= e1_pc;
                thumb_q[wr_q + PW'(1)] <= bus.i_cpsr_ff_t;
                abort_q[wr_q + PW'(1)] <= 1'b0;
            end
        end
    end

    assign bus.o_word_ready  = word_ready;
    assign bus.o_instruction = rec_instr_q;
    assign bus.o_valid       = rec_valid_q;
    assign bus.o_pair        = rec_pair_q;
    assign bus.o_thumb       = rec_thumb_q;
    assign bus.o_iabort      = rec_iabort_q;
    assign bus.o_pc          = rec_pc_q;
    assign bus.o_pc_plus_8   = rec_pc8_q;
    assign bus.o_level       = level_q;
endmodule

// File: tb/tb_zap_mode16_unpack_queue.sv
// Testbench for zap_mode16_unpack_queue: directed scenarios, then randomized traffic
// checked against a queue-based reference model.
module tb_zap_mode16_unpack_queue;
    localparam int unsigned DEPTH = 8;
`ifdef ZAP_MODE16_PAIR_FUSE_EN
    localparam bit FUSE = 1'b1;
`else
    localparam bit FUSE = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst, clr_wb, dstall, clr_alu, clr_dec, st_sh, st_is, st_dec;

    zap_mode16_unpack_queue_if #(.DEPTH(DEPTH)) bus ();

    zap_mode16_unpack_queue #(.DEPTH(DEPTH)) dut (
        .i_clk                  (clk),
        .i_reset                (rst),
        .i_clear_from_writeback (clr_wb),
        .i_data_stall           (dstall),
        .i_clear_from_alu       (clr_alu),
        .i_clear_from_decode    (clr_dec),
        .i_stall_from_shifter   (st_sh),
        .i_stall_from_issue     (st_is),
        .i_stall_from_decode    (st_dec),
        .bus                    (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] hw;
        logic [31:0] pc;
        logic        thumb;
        logic        abort;
    } ent_t;

    ent_t        mq[$];
    logic        m_valid, m_pair, m_thumb, m_iabort;
    logic [31:0] m_instr, m_pc;
    int unsigned n_total = 0;
    int unsigned n_bad   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic m_set(input ent_t h, input logic [31:0] instr, input logic pair);
        m_valid  = 1'b1;
        m_instr  = instr;
        m_pair   = pair;
        m_thumb  = h.thumb;
        m_iabort = h.abort;
        m_pc     = h.pc;
    endtask

    // Reference: one clock of the queue, applied to the current inputs
    task automatic model_step();
        logic stall, flush;
        int   sz0, pop;
        ent_t h;
        logic [31:0] pc;
        logic t;
        if (rst) begin
            mq.delete();
            {m_valid, m_pair, m_thumb, m_iabort} = 4'b0;
            m_instr = 32'd0;
            m_pc    = 32'd0;
            return;
        end
        sz0   = mq.size();
        stall = st_sh || st_is || st_dec || dstall;
        flush = clr_wb || (!dstall && clr_alu) || (!stall && clr_dec);
        pop   = 0;
        if (flush) begin
            m_valid = 1'b0; m_iabort = 1'b0; m_pair = 1'b0;
        end else if (!stall) begin
            if (sz0 == 0) begin
                m_valid = 1'b0;
            end else begin
                h = mq[0];
                if (h.abort) begin
                    m_set(h, 32'd0, 1'b0); pop = 1;
                end else if (!h.thumb) begin
                    if (sz0 >= 2) begin m_set(h, {mq[1].hw, h.hw}, 1'b0); pop = 2; end
                    else m_valid = 1'b0;
                end else if (FUSE && h.hw[15:11] == 5'b11110 && sz0 == 1) begin
                    m_valid = 1'b0;
                end else if (FUSE && h.hw[15:11] == 5'b11110 && mq[1].thumb && !mq[1].abort
                             && mq[1].hw[15:11] == 5'b11111) begin
                    m_set(h, {h.hw, mq[1].hw}, 1'b1); pop = 2;
                end else begin
                    m_set(h, {16'd0, h.hw}, 1'b0); pop = 1;
                end
            end
        end
        repeat (pop) void'(mq.pop_front());
        if (flush) mq.delete();
        if (!flush && bus.i_word_valid && sz0 + 2 <= int'(DEPTH)) begin
            pc = bus.i_word_pc;
            t  = bus.i_cpsr_ff_t;
            if (bus.i_word_iabort) begin
                mq.push_back('{16'd0, pc, t, 1'b1});
            end else if (t && !pc[1]) begin
                mq.push_back('{bus.i_word[15:0], pc, 1'b1, 1'b0});
                mq.push_back('{bus.i_word[31:16], pc + 32'd2, 1'b1, 1'b0});
            end else if (t) begin
                mq.push_back('{bus.i_word[31:16], pc, 1'b1, 1'b0});
            end else begin
                mq.push_back('{bus.i_word[15:0], pc, 1'b0, 1'b0});
                mq.push_back('{bus.i_word[31:16], pc, 1'b0, 1'b0});
            end
        end
    endtask

    // One clock: check ready, advance the model, then compare registered outputs
    task automatic cycle();
        logic was_rst;
        logic [31:0] exp_pc8;
        was_rst = rst;
        if (!rst) chk("word_ready", 32'(bus.o_word_ready), 32'(mq.size() + 2 <= int'(DEPTH)));
        model_step();
        @(posedge clk);
        #1;
        chk("valid", 32'(bus.o_valid), 32'(m_valid));
        chk("level", 32'(bus.o_level), 32'(mq.size()));
        if (m_valid || was_rst) begin
            exp_pc8 = was_rst ? 32'd0 : (m_pc + (m_thumb ? 32'd4 : 32'd8));
            chk("instr",   bus.o_instruction,     m_instr);
            chk("pc",      bus.o_pc,              m_pc);
            chk("pc8",     bus.o_pc_plus_8,       exp_pc8);
            chk("thumb",   32'(bus.o_thumb),      32'(m_thumb));
            chk("pair",    32'(bus.o_pair),       32'(m_pair));
            chk("iabort",  32'(bus.o_iabort),     32'(m_iabort));
        end
    endtask

    task automatic put(input logic [31:0] w, input logic [31:0] pc, input logic t, input logic ab);
        bus.i_word        = w;
        bus.i_word_pc     = pc;
        bus.i_cpsr_ff_t   = t;
        bus.i_word_iabort = ab;
        bus.i_word_valid  = 1'b1;
        cycle();
        bus.i_word_valid  = 1'b0;
        bus.i_word_iabort = 1'b0;
    endtask

    function automatic logic [15:0] rand_hw();
        case ($urandom_range(0, 2))
            0:       return 16'($urandom);
            1:       return {5'b11110, 11'($urandom)};
            default: return {5'b11111, 11'($urandom)};
        endcase
    endfunction

    initial begin
        logic [31:0] pc;
        logic t;
        rst = 1'b1;
        {clr_wb, dstall, clr_alu, clr_dec, st_sh, st_is, st_dec} = 7'b0;
        bus.i_word = 32'd0; bus.i_word_pc = 32'd0; bus.i_cpsr_ff_t = 1'b0;
        bus.i_word_valid = 1'b0; bus.i_word_iabort = 1'b0;
        cycle();
        cycle();
        rst = 1'b0;

        // Compressed word, two halfwords
        put(32'h4770_2001, 32'h100, 1'b1, 1'b0);
        cycle();
        chk("t1_a_instr", bus.o_instruction, 32'h0000_2001);
        chk("t1_a_pc8",   bus.o_pc_plus_8,   32'h104);
        cycle();
        chk("t1_b_instr", bus.o_instruction, 32'h0000_4770);
        chk("t1_b_pc",    bus.o_pc,          32'h102);
        chk("t1_level",   32'(bus.o_level),  32'd0);

        // BL pair inside one word
        put(32'hF800_F000, 32'h200, 1'b1, 1'b0);
        cycle();
`ifdef ZAP_MODE16_PAIR_FUSE_EN
        chk("t2_instr", bus.o_instruction, 32'hF000_F800);
        chk("t2_pair",  32'(bus.o_pair),   32'd1);
        chk("t2_pc",    bus.o_pc,          32'h200);
        cycle();
`else
        chk("t2_a_instr", bus.o_instruction, 32'h0000_F000);
        chk("t2_a_pair",  32'(bus.o_pair),   32'd0);
        cycle();
        chk("t2_b_instr", bus.o_instruction, 32'h0000_F800);
        chk("t2_b_pc",    bus.o_pc,          32'h202);
`endif

        // BL prefix split across two fetches
        put(32'hF000_1234, 32'h302, 1'b1, 1'b0);
        cycle();
`ifdef ZAP_MODE16_PAIR_FUSE_EN
        chk("t3_wait", 32'(bus.o_valid), 32'd0);
`else
        chk("t3_alone", bus.o_instruction, 32'h0000_F000);
`endif
        cycle();
        put(32'h1234_F801, 32'h304, 1'b1, 1'b0);
        cycle();
`ifdef ZAP_MODE16_PAIR_FUSE_EN
        chk("t3_fused", bus.o_instruction, 32'hF000_F801);
        chk("t3_pc",    bus.o_pc,          32'h302);
`else
        chk("t3_sfx",   bus.o_instruction, 32'h0000_F801);
`endif
        cycle();
        chk("t3_tail", bus.o_instruction, 32'h0000_1234);

        // Non-compressed word
        put(32'hE3A0_0001, 32'h400, 1'b0, 1'b0);
        cycle();
        chk("t4_instr", bus.o_instruction,  32'hE3A0_0001);
        chk("t4_thumb", 32'(bus.o_thumb),   32'd0);
        chk("t4_pc8",   bus.o_pc_plus_8,    32'h408);

        // Fill under issue stall, then ALU clear
        st_is = 1'b1;
        for (int i = 0; i < 8 && bus.o_word_ready; i++) put(32'hE1A0_0000 | 32'(i), 32'h600 + 32'(4 * i), 1'b0, 1'b0);
        chk("t5_full_ready", 32'(bus.o_word_ready), 32'd0);
        chk("t5_full_level", 32'(bus.o_level),      32'd8);
        clr_alu = 1'b1;
        cycle();
        clr_alu = 1'b0;
        st_is   = 1'b0;
        chk("t5_clr_valid", 32'(bus.o_valid), 32'd0);
        chk("t5_clr_level", 32'(bus.o_level), 32'd0);

        // data_stall blocks ALU clear but not writeback clear
        put(32'h4770_2001, 32'h100, 1'b1, 1'b0);
        cycle();
        dstall = 1'b1; clr_alu = 1'b1;
        cycle();
        chk("t6_hold_valid", 32'(bus.o_valid),  32'd1);
        chk("t6_hold_instr", bus.o_instruction, 32'h0000_2001);
        chk("t6_hold_level", 32'(bus.o_level),  32'd1);
        clr_alu = 1'b0; clr_wb = 1'b1;
        cycle();
        chk("t6_wb_valid", 32'(bus.o_valid), 32'd0);
        chk("t6_wb_level", 32'(bus.o_level), 32'd0);
        dstall = 1'b0; clr_wb = 1'b0;

        // Aborted fetch
        put(32'h0, 32'h500, 1'b1, 1'b1);
        cycle();
        chk("t7_iabort", 32'(bus.o_iabort), 32'd1);
        chk("t7_pc",     bus.o_pc,          32'h500);

        // Randomized traffic
        for (int n = 0; n < 4000; n++) begin
            rst     = ($urandom_range(0, 299) == 0);
            clr_wb  = ($urandom_range(0, 59) == 0);
            dstall  = ($urandom_range(0, 7) == 0);
            clr_alu = ($urandom_range(0, 59) == 0);
            clr_dec = ($urandom_range(0, 39) == 0);
            st_sh   = ($urandom_range(0, 11) == 0);
            st_is   = ($urandom_range(0, 5) == 0);
            st_dec  = ($urandom_range(0, 11) == 0);
            t  = ($urandom_range(0, 3) != 0);
            pc = $urandom;
            pc[0] = 1'b0;
            if (!t) pc[1] = 1'b0;
            bus.i_word        = {rand_hw(), rand_hw()};
            bus.i_word_pc     = pc;
            bus.i_cpsr_ff_t   = t;
            bus.i_word_valid  = ($urandom_range(0, 2) != 0);
            bus.i_word_iabort = ($urandom_range(0, 15) == 0);
            cycle();
        end

        rst = 1'b0;
        {clr_wb, dstall, clr_alu, clr_dec, st_sh, st_is, st_dec} = 7'b0;
        bus.i_word_valid = 1'b0;
        repeat (6) cycle();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
